// File: rtl/sw_debounce_if.sv
// Switch bus between the raw slide-switch source and the debounced consumer.
interface sw_debounce_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] SW;
  logic [WIDTH-1:0] SW_DB;
  logic [WIDTH-1:0] CHG;
  logic             ANY_CHG;

  modport master (output SW, input SW_DB, CHG, ANY_CHG);
  modport slave  (input SW, output SW_DB, CHG, ANY_CHG);
endinterface

// File: rtl/sw_debounce.sv
// Per-bit two-flop synchronizer and stability-count debouncer for the slide switches,
// with one-cycle change pulses on every debounced update.
module sw_debounce #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned STABLE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic         CLK100MHZ,
  input  logic         RST,
  sw_debounce_if.slave sw_bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] sw_db;
  logic [WIDTH-1:0] chg;
  logic             any_chg;
  logic [CNT_W-1:0] cnt [WIDTH];

  logic [WIDTH-1:0] diff_c;
  logic [WIDTH-1:0] upd_c;

  // A bit updates once its synchronized level has differed for the full count.
  always_comb begin
    diff_c = s2 ^ sw_db;
    upd_c  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      upd_c[i] = diff_c[i] && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      s1      <= '0;
      s2      <= '0;
      sw_db   <= '0;
      chg     <= '0;
      any_chg <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1      <= sw_bus.SW;
      s2      <= s1;
      sw_db   <= sw_db ^ upd_c;
      chg     <= upd_c;
      any_chg <= |upd_c;
      // Any cycle of agreement restarts the count; clearing on update keeps it from wrapping.
      for (int i = 0; i < WIDTH; i++) begin
        if (!diff_c[i] || upd_c[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign sw_bus.SW_DB   = sw_db;
  assign sw_bus.CHG     = chg;
  assign sw_bus.ANY_CHG = any_chg;

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce with STABLE_CYCLES=4: per-edge expected outputs are
// queued alongside the stimulus and compared on the falling edge after each rising edge.
module tb_sw_debounce;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned STABLE = 4;

  typedef struct packed {
    logic             rst;
    logic [WIDTH-1:0] sw;
  } stim_t;

  typedef struct packed {
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] chg;
    logic             any;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sw_debounce_if #(.WIDTH(WIDTH)) bus ();

  sw_debounce #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .CLK100MHZ (clk),
    .RST       (rst),
    .sw_bus    (bus)
  );

  always #5 clk = ~clk;

  stim_t stim_q [$];
  exp_t  exp_q  [$];
  int    checks = 0;
  int    fails  = 0;

  task automatic push_stim(input logic r, input logic [WIDTH-1:0] sw, input int n);
    stim_t s;
    s.rst = r;
    s.sw  = sw;
    for (int i = 0; i < n; i++) stim_q.push_back(s);
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] db, input logic [WIDTH-1:0] chg,
                          input logic any, input int n);
    exp_t e;
    e.db  = db;
    e.chg = chg;
    e.any = any;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic apply_next();
    stim_t s;
    s       = stim_q.pop_front();
    rst     = s.rst;
    bus.SW  = s.sw;
  endtask

  task automatic test_reset();
    int   n;
    exp_t e;
    push_stim(1'b1, 16'hFFFF, 3);
    push_stim(1'b0, 16'hFFFF, 8);
    push_exp(16'h0000, 16'h0000, 1'b0, 8);
    push_exp(16'hFFFF, 16'hFFFF, 1'b1, 1);
    push_exp(16'hFFFF, 16'h0000, 1'b0, 2);
    n = stim_q.size();
    for (int t = 0; t <= n; t++) begin
      @(negedge clk);
      if (t > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.SW_DB, bus.CHG, bus.ANY_CHG} !== {e.db, e.chg, e.any}) begin
          fails++;
          $display("FAIL reset edge %0d: SW_DB=%h CHG=%h ANY_CHG=%b, required SW_DB=%h CHG=%h ANY_CHG=%b",
                   t - 1, bus.SW_DB, bus.CHG, bus.ANY_CHG, e.db, e.chg, e.any);
        end
      end
      if (t < n) apply_next();
    end
  endtask

  task automatic test_release();
    int   n;
    exp_t e;
    push_stim(1'b0, 16'h0000, 8);
    push_exp(16'hFFFF, 16'h0000, 1'b0, 5);
    push_exp(16'h0000, 16'hFFFF, 1'b1, 1);
    push_exp(16'h0000, 16'h0000, 1'b0, 2);
    n = stim_q.size();
    for (int t = 0; t <= n; t++) begin
      @(negedge clk);
      if (t > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.SW_DB, bus.CHG, bus.ANY_CHG} !== {e.db, e.chg, e.any}) begin
          fails++;
          $display("FAIL release edge %0d: SW_DB=%h CHG=%h ANY_CHG=%b, required SW_DB=%h CHG=%h ANY_CHG=%b",
                   t - 1, bus.SW_DB, bus.CHG, bus.ANY_CHG, e.db, e.chg, e.any);
        end
      end
      if (t < n) apply_next();
    end
  endtask

  task automatic test_clean_edge();
    int   n;
    exp_t e;
    push_stim(1'b0, 16'h0001, 8);
    push_exp(16'h0000, 16'h0000, 1'b0, 5);
    push_exp(16'h0001, 16'h0001, 1'b1, 1);
    push_exp(16'h0001, 16'h0000, 1'b0, 2);
    n = stim_q.size();
    for (int t = 0; t <= n; t++) begin
      @(negedge clk);
      if (t > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.SW_DB, bus.CHG, bus.ANY_CHG} !== {e.db, e.chg, e.any}) begin
          fails++;
          $display("FAIL clean_edge edge %0d: SW_DB=%h CHG=%h ANY_CHG=%b, required SW_DB=%h CHG=%h ANY_CHG=%b",
                   t - 1, bus.SW_DB, bus.CHG, bus.ANY_CHG, e.db, e.chg, e.any);
        end
      end
      if (t < n) apply_next();
    end
  endtask

  // SW[3]: high 2, low 1, high 3, low 1, then held high from capture edge 7.
  task automatic test_bounce();
    int   n;
    exp_t e;
    push_stim(1'b0, 16'h0009, 2);
    push_stim(1'b0, 16'h0001, 1);
    push_stim(1'b0, 16'h0009, 3);
    push_stim(1'b0, 16'h0001, 1);
    push_stim(1'b0, 16'h0009, 9);
    push_exp(16'h0001, 16'h0000, 1'b0, 12);
    push_exp(16'h0009, 16'h0008, 1'b1, 1);
    push_exp(16'h0009, 16'h0000, 1'b0, 3);
    n = stim_q.size();
    for (int t = 0; t <= n; t++) begin
      @(negedge clk);
      if (t > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.SW_DB, bus.CHG, bus.ANY_CHG} !== {e.db, e.chg, e.any}) begin
          fails++;
          $display("FAIL bounce edge %0d: SW_DB=%h CHG=%h ANY_CHG=%b, required SW_DB=%h CHG=%h ANY_CHG=%b",
                   t - 1, bus.SW_DB, bus.CHG, bus.ANY_CHG, e.db, e.chg, e.any);
        end
      end
      if (t < n) apply_next();
    end
  endtask

  task automatic test_glitch();
    int   n;
    exp_t e;
    push_stim(1'b0, 16'h0089, STABLE - 1);
    push_stim(1'b0, 16'h0009, 9);
    push_exp(16'h0009, 16'h0000, 1'b0, 12);
    n = stim_q.size();
    for (int t = 0; t <= n; t++) begin
      @(negedge clk);
      if (t > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.SW_DB, bus.CHG, bus.ANY_CHG} !== {e.db, e.chg, e.any}) begin
          fails++;
          $display("FAIL glitch edge %0d: SW_DB=%h CHG=%h ANY_CHG=%b, required SW_DB=%h CHG=%h ANY_CHG=%b",
                   t - 1, bus.SW_DB, bus.CHG, bus.ANY_CHG, e.db, e.chg, e.any);
        end
      end
      if (t < n) apply_next();
    end
  endtask

  task automatic test_simultaneous();
    int   n;
    exp_t e;
    push_stim(1'b0, 16'h0000, 8);
    push_stim(1'b0, 16'hA5A5, 8);
    push_exp(16'h0009, 16'h0000, 1'b0, 5);
    push_exp(16'h0000, 16'h0009, 1'b1, 1);
    push_exp(16'h0000, 16'h0000, 1'b0, 7);
    push_exp(16'hA5A5, 16'hA5A5, 1'b1, 1);
    push_exp(16'hA5A5, 16'h0000, 1'b0, 2);
    n = stim_q.size();
    for (int t = 0; t <= n; t++) begin
      @(negedge clk);
      if (t > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.SW_DB, bus.CHG, bus.ANY_CHG} !== {e.db, e.chg, e.any}) begin
          fails++;
          $display("FAIL simultaneous edge %0d: SW_DB=%h CHG=%h ANY_CHG=%b, required SW_DB=%h CHG=%h ANY_CHG=%b",
                   t - 1, bus.SW_DB, bus.CHG, bus.ANY_CHG, e.db, e.chg, e.any);
        end
      end
      if (t < n) apply_next();
    end
  endtask

  // SW[2] captured at edge 8, counted at edges 10-11, reset at edge 12, recaptured at 13.
  task automatic test_reset_mid_count();
    int   n;
    exp_t e;
    push_stim(1'b0, 16'h0000, 8);
    push_stim(1'b0, 16'h0004, 4);
    push_stim(1'b1, 16'h0004, 1);
    push_stim(1'b0, 16'h0004, 8);
    push_exp(16'hA5A5, 16'h0000, 1'b0, 5);
    push_exp(16'h0000, 16'hA5A5, 1'b1, 1);
    push_exp(16'h0000, 16'h0000, 1'b0, 12);
    push_exp(16'h0004, 16'h0004, 1'b1, 1);
    push_exp(16'h0004, 16'h0000, 1'b0, 2);
    n = stim_q.size();
    for (int t = 0; t <= n; t++) begin
      @(negedge clk);
      if (t > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.SW_DB, bus.CHG, bus.ANY_CHG} !== {e.db, e.chg, e.any}) begin
          fails++;
          $display("FAIL reset_mid_count edge %0d: SW_DB=%h CHG=%h ANY_CHG=%b, required SW_DB=%h CHG=%h ANY_CHG=%b",
                   t - 1, bus.SW_DB, bus.CHG, bus.ANY_CHG, e.db, e.chg, e.any);
        end
      end
      if (t < n) apply_next();
    end
  endtask

  initial begin
    bus.SW = 16'hFFFF;
    test_reset();
    test_release();
    test_clean_edge();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid_count();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
